// File: rtl/cpu_fetch_pkg.sv
// Shared types and constants for the fetch datapath (PC/IR unit).
// Contents: FSM state enum, default address/instruction widths,
// reset PC value and the fetch-counter width.
package cpu_fetch_pkg;

  localparam int unsigned DEF_AW       = 8;
  localparam int unsigned DEF_IW       = 10;
  localparam int unsigned DEF_RESET_PC = 0;
  localparam int unsigned FETCH_CNT_W  = 16;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC select: jump target or sequential increment.
// Ports:
//   pc      - current program counter
//   jump    - select target instead of pc+1
//   target  - jump destination
//   next_pc - selected next PC (increment wraps modulo 2^AW)
module pc_next_sel #(
  parameter int unsigned AW = 8
) (
  input  logic [AW-1:0] pc,
  input  logic          jump,
  input  logic [AW-1:0] target,
  output logic [AW-1:0] next_pc
);

  // Increment is naturally modulo 2^AW at this width.
  assign next_pc = jump ? target : (pc + AW'(1));

endmodule

// File: rtl/pc_ir_unit.sv
// PC / IR unit: datapath end of the fetch interface. Owns the program
// counter and instruction register, drives the ROM address, absorbs ROM
// wait states and reports busy so the sequencer holds off.
// Optional feature: define FETCH_COUNT_EN to add a saturating fetch_count
// output counting IR captures.
// Ports:
//   clk, rst_n         - clock, synchronous active-low reset
//   PCload, IRload     - update / capture strobes from the sequencer
//   jump_en, jump_addr - jump redirect, qualified by PCload
//   rom_addr           - ROM address (combinationally equal to pc)
//   rom_data, rom_ready- ROM read data and its valid flag
//   pc, ir             - current PC and instruction
//   ir_valid, ir_new   - IR holds an instruction / one-cycle capture pulse
//   busy               - waiting on ROM, strobes ignored
//   fetch_count        - (FETCH_COUNT_EN only) number of captures
module pc_ir_unit
  import cpu_fetch_pkg::*;
#(
  parameter int unsigned AW       = DEF_AW,
  parameter int unsigned IW       = DEF_IW,
  parameter int unsigned RESET_PC = DEF_RESET_PC
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          PCload,
  input  logic          IRload,
  input  logic          jump_en,
  input  logic [AW-1:0] jump_addr,
  output logic [AW-1:0] rom_addr,
  input  logic [IW-1:0] rom_data,
  input  logic          rom_ready,
  output logic [AW-1:0] pc,
  output logic [IW-1:0] ir,
  output logic          ir_valid,
  output logic          ir_new,
  output logic          busy
`ifdef FETCH_COUNT_EN
  ,
  output logic [FETCH_CNT_W-1:0] fetch_count
`endif
);

  state_t        state;
  logic          pend_pc;
  logic          pend_jmp;
  logic [AW-1:0] pend_tgt;

  logic          sel_jump;
  logic [AW-1:0] sel_tgt;
  logic [AW-1:0] pc_nxt;
  logic          capture;

  // While waiting, the PC update uses the redirect latched at IRload time.
  assign sel_jump = (state == S_WAIT) ? pend_jmp : jump_en;
  assign sel_tgt  = (state == S_WAIT) ? pend_tgt : jump_addr;

  pc_next_sel #(.AW(AW)) u_pc_next_sel (
    .pc      (pc),
    .jump    (sel_jump),
    .target  (sel_tgt),
    .next_pc (pc_nxt)
  );

  assign rom_addr = pc;

  assign capture = rom_ready && ((state == S_WAIT) || IRload);

  // Fetch FSM with PC/IR and pending-update registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      pc       <= AW'(RESET_PC);
      ir       <= '0;
      ir_valid <= 1'b0;
      ir_new   <= 1'b0;
      busy     <= 1'b0;
      pend_pc  <= 1'b0;
      pend_jmp <= 1'b0;
      pend_tgt <= '0;
    end else begin
      ir_new <= 1'b0;
      case (state)
        S_IDLE: begin
          if (IRload) begin
            if (rom_ready) begin
              ir       <= rom_data;
              ir_new   <= 1'b1;
              ir_valid <= 1'b1;
              if (PCload) pc <= pc_nxt;
            end else begin
              // Defer the PC update so rom_addr stays put during the wait.
              pend_pc  <= PCload;
              pend_jmp <= jump_en;
              pend_tgt <= jump_addr;
              busy     <= 1'b1;
              state    <= S_WAIT;
            end
          end else if (PCload) begin
            pc <= pc_nxt;
          end
        end
        S_WAIT: begin
          // Strobes are dropped here; only rom_ready matters.
          if (rom_ready) begin
            ir       <= rom_data;
            ir_new   <= 1'b1;
            ir_valid <= 1'b1;
            if (pend_pc) pc <= pc_nxt;
            pend_pc  <= 1'b0;
            pend_jmp <= 1'b0;
            busy     <= 1'b0;
            state    <= S_IDLE;
          end
        end
      endcase
    end
  end

`ifdef FETCH_COUNT_EN
  // Saturating capture counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_count <= '0;
    end else if (capture && (fetch_count != '1)) begin
      fetch_count <= fetch_count + FETCH_CNT_W'(1);
    end
  end
`else
  logic unused_capture;
  assign unused_capture = capture;
`endif

endmodule

// File: tb/tb_pc_ir_unit.sv
// Self-checking bench for pc_ir_unit: directed scenarios followed by
// randomized strobes and ROM wait states, compared against a
// transaction-level reference model every cycle.
module tb_pc_ir_unit;

  localparam int unsigned AW = 8;
  localparam int unsigned IW = 10;
  localparam int PC_MOD = 256;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          PCload, IRload, jump_en, rom_ready;
  logic [AW-1:0] jump_addr, rom_addr, pc;
  logic [IW-1:0] rom_data, ir;
  logic          ir_valid, ir_new, busy;
`ifdef FETCH_COUNT_EN
  logic [15:0]   fetch_count;
`endif

  pc_ir_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .PCload    (PCload),
    .IRload    (IRload),
    .jump_en   (jump_en),
    .jump_addr (jump_addr),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .rom_ready (rom_ready),
    .pc        (pc),
    .ir        (ir),
    .ir_valid  (ir_valid),
    .ir_new    (ir_new),
    .busy      (busy)
`ifdef FETCH_COUNT_EN
    ,
    .fetch_count (fetch_count)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: transaction-level view of the fetch unit.
  logic [IW-1:0] rom_mem [PC_MOD];
  int m_pc, m_ir, m_valid, m_new, m_waiting, m_cnt;
  int p_pc, p_jmp, p_tgt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic int next_pc(input int cur, input int j, input int tgt);
    return j ? tgt : (cur + 1) % PC_MOD;
  endfunction

  task automatic model_capture();
    m_ir    = int'(rom_mem[m_pc]);
    m_new   = 1;
    m_valid = 1;
    if (m_cnt < 65535) m_cnt++;
  endtask

  // One clock: drive inputs, advance model, compare after the edge.
  task automatic step(input int rst, input int pcl, input int irl,
                      input int je, input int ja, input int rdy);
    check("rom_addr_pre", 32'(rom_addr), 32'(m_pc));
    rst_n     = rst ? 1'b0 : 1'b1;
    PCload    = pcl[0];
    IRload    = irl[0];
    jump_en   = je[0];
    jump_addr = AW'(ja);
    rom_ready = rdy[0];
    rom_data  = rom_mem[m_pc];
    if (rst) begin
      m_pc = 0; m_ir = 0; m_valid = 0; m_new = 0; m_waiting = 0; m_cnt = 0;
      p_pc = 0; p_jmp = 0; p_tgt = 0;
    end else begin
      m_new = 0;
      if (m_waiting) begin
        if (rdy) begin
          model_capture();
          if (p_pc) m_pc = next_pc(m_pc, p_jmp, p_tgt);
          m_waiting = 0;
        end
      end else if (irl) begin
        if (rdy) begin
          model_capture();
          if (pcl) m_pc = next_pc(m_pc, je, ja);
        end else begin
          m_waiting = 1;
          p_pc = pcl; p_jmp = je; p_tgt = ja;
        end
      end else if (pcl) begin
        m_pc = next_pc(m_pc, je, ja);
      end
    end
    @(posedge clk);
    @(negedge clk);
    check("pc",       32'(pc),       32'(m_pc));
    check("rom_addr", 32'(rom_addr), 32'(m_pc));
    check("ir",       32'(ir),       32'(m_ir));
    check("ir_valid", 32'(ir_valid), 32'(m_valid));
    check("ir_new",   32'(ir_new),   32'(m_new));
    check("busy",     32'(busy),     32'(m_waiting));
`ifdef FETCH_COUNT_EN
    check("fetch_count", 32'(fetch_count), 32'(m_cnt));
`endif
  endtask

  initial begin
    for (int i = 0; i < PC_MOD; i++) rom_mem[i] = IW'($urandom);
    rom_mem[0] = 10'h2A5;
    rst_n = 1'b0; PCload = 0; IRload = 0; jump_en = 0; jump_addr = '0;
    rom_ready = 0; rom_data = '0;
    m_pc = 0;
    @(negedge clk);

    // Reset state.
    step(1, 0, 0, 0, 0, 0);
    check("reset_pc", 32'(pc), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);

    // Zero-wait fetch with PC increment.
    step(0, 1, 1, 0, 0, 1);
    check("first_ir", 32'(ir), 32'h2A5);
    check("first_pc", 32'(pc), 32'd1);
    check("first_new", 32'(ir_new), 32'd1);

    // Walk to pc=5, then a 3-cycle wait with strobes pulsed while busy.
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0);
    step(0, 1, 1, 1, 8'h33, 0);
    step(0, 1, 0, 0, 0, 0);
    check("wait_busy", 32'(busy), 32'd1);
    check("wait_addr", 32'(rom_addr), 32'd5);
    step(0, 0, 0, 0, 0, 1);
    check("wait_pc", 32'(pc), 32'd6);
    check("wait_busy_clr", 32'(busy), 32'd0);
    check("wait_ir", 32'(ir), 32'(rom_mem[5]));

    // Jump with capture: IR from old pc, pc = target.
    step(0, 1, 1, 1, 8'h40, 1);
    check("jump_ir", 32'(ir), 32'(rom_mem[6]));
    check("jump_pc", 32'(pc), 32'h40);

    // Wrap from 0xFF to 0x00; jump_en alone has no effect.
    step(0, 1, 0, 1, 8'hFF, 0);
    step(0, 0, 0, 1, 8'h12, 0);
    check("nojump_pc", 32'(pc), 32'hFF);
    step(0, 1, 0, 0, 0, 0);
    check("wrap_pc", 32'(pc), 32'h00);

    // Reset during a wait at pc=7 with a pending PC update.
    step(0, 1, 0, 1, 7, 0);
    step(0, 1, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0, 1);
    check("rst_wait_pc", 32'(pc), 32'd0);
    check("rst_wait_valid", 32'(ir_valid), 32'd0);
    step(0, 0, 0, 0, 0, 1);
    check("rst_wait_new", 32'(ir_new), 32'd0);

`ifdef FETCH_COUNT_EN
    step(0, 0, 1, 0, 0, 1);
    step(0, 1, 1, 0, 0, 1);
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    check("fetch_count3", 32'(fetch_count), 32'd3);
`endif

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) < 2) ? 1 : 0,
           int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
           int'($urandom_range(0, 1)), int'($urandom_range(0, 255)),
           ($urandom_range(0, 99) < 55) ? 1 : 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
